// File: rtl/dram_pkg.sv
// Shared DRAM port definitions: widths, command encodings, request struct, stage state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_pkg;

    localparam int DRAM_ADDR_W = 27;
    localparam int DRAM_DATA_W = 128;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    // Layout of one entry of the DRAM controller request FIFO.
    typedef struct packed {
        logic                   cmd;
        logic [DRAM_ADDR_W-1:0] addr;
        logic [DRAM_DATA_W-1:0] data;
    } dram_req_t;

    // One-entry output stage toward the DRAM request FIFO.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } stage_e;

endpackage

// File: rtl/dram_ord_fifo.sv
// Ordering FIFO: remembers which port issued each outstanding DRAM read.
// Latency: push visible at head the cycle after; pop consumes head on the clock edge.
// Backpressure: o_full/o_empty exported; pushes when full and pops when empty are ignored.
// Ports: clk/rst; i_push/i_push_dat; i_pop; o_pop_dat (head); o_count, o_empty, o_full.
module dram_ord_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_dat,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_dat,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push    = i_push & ~o_full;
    assign w_pop     = i_pop & ~o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin share of one DRAM request/response port between fetch (port 0) and load/store (port 1).
// Latency: rq_valid -> dram_req_en 1 cycle; dram_rsp_en -> rs_valid 1 cycle.
// Backpressure: dram_req_rdy low holds the output stage and drops rq_ready; reads also stall at MAX_OUTST.
// Ports: rq_* per-port requests (rq_ready combinational grant); rs_* routed read responses;
//        dram_req_* registered request toward DRAM; dram_rsp_* read data from DRAM; err_orphan sticky.
module dram_port_arbiter
    import dram_pkg::*;
#(
    parameter int ADDR_W    = DRAM_ADDR_W,
    parameter int DATA_W    = DRAM_DATA_W,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rq_valid,
    output logic [1:0]        rq_ready,
    input  logic [1:0]        rq_cmd,
    input  logic [ADDR_W-1:0] rq_addr0,
    input  logic [ADDR_W-1:0] rq_addr1,
    input  logic [DATA_W-1:0] rq_data0,
    input  logic [DATA_W-1:0] rq_data1,
    output logic [1:0]        rs_valid,
    output logic [DATA_W-1:0] rs_data,
    output logic              dram_req_en,
    input  logic              dram_req_rdy,
    output logic              dram_req_cmd,
    output logic [ADDR_W-1:0] dram_req_addr,
    output logic [DATA_W-1:0] dram_req_data,
    input  logic              dram_rsp_en,
    output logic              dram_rsp_rdy,
    input  logic [DATA_W-1:0] dram_rsp_data,
    output logic              err_orphan
);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    stage_e            r_state;
    stage_e            w_state_nxt;
    logic              r_ptr;
    logic              w_ptr_nxt;
    logic              r_cmd;
    logic              r_port;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_rs_valid;
    logic [DATA_W-1:0] r_rs_data;
    logic              r_err;

    logic              w_xfer;
    logic              w_free;
    logic              w_pend_rd;
    logic [CNT_W:0]    w_rd_load;
    logic              w_rd_ok;
    logic [1:0]        w_elig;
    logic [1:0]        w_gnt;
    logic              w_push;
    logic              w_pop;
    logic              w_head;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_empty;
    logic              w_full;

    assign w_xfer    = (r_state == ST_BUSY) & dram_req_rdy;
    assign w_free    = (r_state == ST_IDLE) | dram_req_rdy;
    // A read sitting in the stage becomes outstanding on its transfer edge, so count it now.
    assign w_pend_rd = (r_state == ST_BUSY) & (r_cmd == CMD_READ);
    assign w_rd_load = {1'b0, w_cnt} + {{CNT_W{1'b0}}, w_pend_rd};
    assign w_rd_ok   = (w_rd_load < (CNT_W+1)'(MAX_OUTST));

    always_comb begin
        w_elig    = '0;
        w_gnt     = '0;
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < 2; i++) begin
            w_elig[i] = rq_valid[i] & w_free & ((rq_cmd[i] == CMD_WRITE) | w_rd_ok);
        end
        if (&w_elig) begin
            // Contention: serve the favoured port, then favour the other one.
            w_gnt     = r_ptr ? 2'b10 : 2'b01;
            w_ptr_nxt = ~r_ptr;
        end else begin
            w_gnt = w_elig;
        end
    end

    assign rq_ready = w_gnt;

    always_comb begin
        w_state_nxt = r_state;
        if (|w_gnt) begin
            w_state_nxt = ST_BUSY;
        end else if (w_xfer) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_cmd   <= CMD_WRITE;
            r_port  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (|w_gnt) begin
                r_port <= w_gnt[1];
                r_cmd  <= w_gnt[1] ? rq_cmd[1] : rq_cmd[0];
                r_addr <= w_gnt[1] ? rq_addr1  : rq_addr0;
                r_data <= w_gnt[1] ? rq_data1  : rq_data0;
            end
        end
    end

    assign dram_req_en   = (r_state == ST_BUSY);
    assign dram_req_cmd  = r_cmd;
    assign dram_req_addr = r_addr;
    assign dram_req_data = r_data;

    // Port id is recorded only once the read has actually left for DRAM.
    assign w_push = w_xfer & (r_cmd == CMD_READ) & ~w_full;
    assign w_pop  = dram_rsp_en & ~w_empty;

    dram_ord_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTST)
    ) u_ord_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (r_port),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_count    (w_cnt),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs_valid <= '0;
            r_rs_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rs_valid <= '0;
            if (w_pop) begin
                r_rs_valid <= w_head ? 2'b10 : 2'b01;
                r_rs_data  <= dram_rsp_data;
            end
            if (dram_rsp_en & w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dram_rsp_rdy = 1'b1;
    assign rs_valid     = r_rs_valid;
    assign rs_data      = r_rs_data;
    assign err_orphan   = r_err;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed self-checking bench for dram_port_arbiter.
// Latency: inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Backpressure: dram_req_rdy and dram_rsp_en driven directly by the bench.
module tb_dram_port_arbiter;
    import dram_pkg::*;

    localparam int AW = 27;
    localparam int DW = 128;

    logic          clk;
    logic          rst;
    logic [1:0]    rq_valid;
    logic [1:0]    rq_ready;
    logic [1:0]    rq_cmd;
    logic [AW-1:0] rq_addr0;
    logic [AW-1:0] rq_addr1;
    logic [DW-1:0] rq_data0;
    logic [DW-1:0] rq_data1;
    logic [1:0]    rs_valid;
    logic [DW-1:0] rs_data;
    logic          dram_req_en;
    logic          dram_req_rdy;
    logic          dram_req_cmd;
    logic [AW-1:0] dram_req_addr;
    logic [DW-1:0] dram_req_data;
    logic          dram_rsp_en;
    logic          dram_rsp_rdy;
    logic [DW-1:0] dram_rsp_data;
    logic          err_orphan;

    int n_cmp  = 0;
    int n_fail = 0;
    int xfer_cnt = 0;
    int rs_cnt   = 0;
    int base;

    localparam logic [DW-1:0] D1 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [DW-1:0] D2 = 128'h00000000111111112222222233333333;
    localparam logic [DW-1:0] W2 = 128'hfedcba98765432100123456789abcdef;

    dram_port_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_OUTST (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rq_valid      (rq_valid),
        .rq_ready      (rq_ready),
        .rq_cmd        (rq_cmd),
        .rq_addr0      (rq_addr0),
        .rq_addr1      (rq_addr1),
        .rq_data0      (rq_data0),
        .rq_data1      (rq_data1),
        .rs_valid      (rs_valid),
        .rs_data       (rs_data),
        .dram_req_en   (dram_req_en),
        .dram_req_rdy  (dram_req_rdy),
        .dram_req_cmd  (dram_req_cmd),
        .dram_req_addr (dram_req_addr),
        .dram_req_data (dram_req_data),
        .dram_rsp_en   (dram_rsp_en),
        .dram_rsp_rdy  (dram_rsp_rdy),
        .dram_rsp_data (dram_rsp_data),
        .err_orphan    (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dram_req_en && dram_req_rdy) xfer_cnt <= xfer_cnt + 1;
        if (|rs_valid)                   rs_cnt   <= rs_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rq_valid = '0; rq_cmd = '0; rq_addr0 = '0; rq_addr1 = '0;
        rq_data0 = '0; rq_data1 = '0; dram_req_rdy = 1'b1; dram_rsp_en = 1'b0; dram_rsp_data = '0;
        tick(); tick();
        // Reset state
        chk("rst_req_en",   dram_req_en, 0);
        chk("rst_req_cmd",  dram_req_cmd, 0);
        chk("rst_req_addr", dram_req_addr, 0);
        chk("rst_req_data", dram_req_data, 0);
        chk("rst_rs_valid", rs_valid, 0);
        chk("rst_rs_data",  rs_data, 0);
        chk("rst_err",      err_orphan, 0);
        chk("rsp_rdy",      dram_rsp_rdy, 1);
        rst = 1'b0;
        tick();

        // Single write from port 0
        base = xfer_cnt;
        rq_valid = 2'b01; rq_cmd = 2'b00; rq_addr0 = 27'h300; rq_data0 = D1;
        #1 chk("wr_ready", rq_ready, 2'b01);
        tick();
        rq_valid = 2'b00;
        chk("wr_en",   dram_req_en, 1);
        chk("wr_cmd",  dram_req_cmd, 0);
        chk("wr_addr", dram_req_addr, 27'h300);
        chk("wr_data", dram_req_data, D1);
        tick();
        chk("wr_en_drop", dram_req_en, 0);
        chk("wr_xfers",   xfer_cnt - base, 1);
        chk("wr_no_rs",   rs_valid, 0);

        // Contention: both ports reading, alternating grants
        rq_cmd = 2'b11; rq_addr0 = 27'h300; rq_addr1 = 27'h400; rq_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 chk("ct_ready", rq_ready, (i % 2) ? 2'b10 : 2'b01);
            tick();
            chk("ct_en",   dram_req_en, 1);
            chk("ct_cmd",  dram_req_cmd, 1);
            chk("ct_addr", dram_req_addr, (i % 2) ? 27'h400 : 27'h300);
        end
        rq_valid = 2'b00;
        tick();
        chk("ct_idle", dram_req_en, 0);
        for (int i = 0; i < 4; i++) begin
            dram_rsp_en = 1'b1; dram_rsp_data = 128'hC0DE0000 + 128'(i);
            tick();
            chk("ct_rs_valid", rs_valid, (i % 2) ? 2'b10 : 2'b01);
            chk("ct_rs_data",  rs_data, 128'hC0DE0000 + 128'(i));
        end
        dram_rsp_en = 1'b0;
        tick();
        chk("ct_rs_end", rs_valid, 0);

        // Backpressure on a pending write
        dram_req_rdy = 1'b0;
        rq_valid = 2'b01; rq_cmd = 2'b00; rq_addr0 = 27'h400; rq_data0 = D2;
        #1 chk("bp_ready0", rq_ready, 2'b01);
        tick();
        rq_valid = 2'b10; rq_addr1 = 27'h123; rq_data1 = '0;
        base = xfer_cnt;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_ready", rq_ready, 2'b00);
            chk("bp_en",   dram_req_en, 1);
            chk("bp_cmd",  dram_req_cmd, 0);
            chk("bp_addr", dram_req_addr, 27'h400);
            chk("bp_data", dram_req_data, D2);
            tick();
        end
        rq_valid = 2'b00; dram_req_rdy = 1'b1;
        tick();
        chk("bp_en_drop", dram_req_en, 0);
        tick();
        chk("bp_xfers", xfer_cnt - base, 1);

        // Outstanding limit: port 1 issues 5 reads with no responses
        base = xfer_cnt;
        rq_cmd = 2'b10; rq_addr1 = 27'h500; rq_valid = 2'b10;
        for (int c = 0; c < 7; c++) begin
            #1 chk("ol_ready", rq_ready, (c < 4) ? 2'b10 : 2'b00);
            tick();
            if (c < 4) rq_addr1 = rq_addr1 + 1'b1;
        end
        chk("ol_xfers", xfer_cnt - base, 4);
        chk("ol_en",    dram_req_en, 0);
        dram_rsp_en = 1'b1; dram_rsp_data = 128'hA5;
        #1 chk("ol_ready_full", rq_ready, 2'b00);
        tick();
        dram_rsp_en = 1'b0;
        chk("ol_rs_valid", rs_valid, 2'b10);
        chk("ol_rs_data",  rs_data, 128'hA5);
        #1 chk("ol_ready_again", rq_ready, 2'b10);
        tick();
        rq_valid = 2'b00;
        chk("ol_5th_addr", dram_req_addr, 27'h504);
        tick();
        chk("ol_xfers5", xfer_cnt - base, 5);
        for (int i = 0; i < 4; i++) begin
            dram_rsp_en = 1'b1; dram_rsp_data = 128'hB0 + 128'(i);
            tick();
            chk("ol_drain", rs_valid, 2'b10);
        end
        dram_rsp_en = 1'b0;
        tick();

        // Round trip: write then read back through port 1
        rq_valid = 2'b10; rq_cmd = 2'b00; rq_addr1 = 27'h400; rq_data1 = W2;
        #1 chk("rt_wr_ready", rq_ready, 2'b10);
        tick();
        chk("rt_wr_data", dram_req_data, W2);
        rq_cmd = 2'b10;
        #1 chk("rt_rd_ready", rq_ready, 2'b10);
        tick();
        rq_valid = 2'b00;
        chk("rt_rd_cmd",  dram_req_cmd, 1);
        chk("rt_rd_addr", dram_req_addr, 27'h400);
        tick();
        dram_rsp_en = 1'b1; dram_rsp_data = W2;
        tick();
        dram_rsp_en = 1'b0;
        chk("rt_rs_valid", rs_valid, 2'b10);
        chk("rt_rs_data",  rs_data, W2);
        tick();
        chk("rt_rs_pulse", rs_valid, 0);

        // Orphans after a mid-burst reset
        rq_valid = 2'b01; rq_cmd = 2'b01; rq_addr0 = 27'h600;
        #1 chk("or_ready0", rq_ready, 2'b01);
        tick();
        rq_addr0 = 27'h601;
        #1 chk("or_ready1", rq_ready, 2'b01);
        tick();
        rq_valid = 2'b00;
        tick();
        rq_valid = 2'b01; rq_addr0 = 27'h602;
        #1 chk("or_ready2", rq_ready, 2'b01);
        tick();
        rq_valid = 2'b00; dram_req_rdy = 1'b0;
        tick();
        chk("or_held", dram_req_en, 1);
        rst = 1'b1;
        #1 chk("or_rst_en", dram_req_en, 0);
        chk("or_rst_addr", dram_req_addr, 0);
        tick();
        rst = 1'b0; dram_req_rdy = 1'b1;
        tick();
        chk("or_err_clear", err_orphan, 0);
        dram_rsp_en = 1'b1; dram_rsp_data = 128'hDEAD;
        tick();
        chk("or_rs0",  rs_valid, 0);
        chk("or_err0", err_orphan, 1);
        tick();
        dram_rsp_en = 1'b0;
        chk("or_rs1",  rs_valid, 0);
        chk("or_err1", err_orphan, 1);
        repeat (3) tick();
        chk("or_sticky", err_orphan, 1);
        rst = 1'b1;
        #1 chk("or_err_rst", err_orphan, 0);
        tick();
        rst = 1'b0;
        tick();

        chk("rs_total", rs_cnt, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
